// File: rtl/ft60x_bus_controller.sv
// FT600/FT601 synchronous 245-FIFO bus master with fair RX/TX arbitration and burst limiting.
// Define FT60X_STATS_EN to add saturating rx_word_count / tx_word_count outputs.
module ft60x_bus_controller #(
   parameter int  DATA_W    = 32,
   parameter int  MAX_BURST = 64,
   localparam int BE_W      = DATA_W / 8,
   localparam int CNT_W     = $clog2(MAX_BURST + 1)
) (
   input  logic              clk,
   input  logic              rst_l,
   input  logic              usb_tx_full,
   input  logic              usb_rx_empty,
   output logic              usb_wren_l,
   output logic              usb_rden_l,
   output logic              usb_outen_l,
   output logic              usb_rst_l,
   inout  wire  [DATA_W-1:0] data,
   inout  wire  [BE_W-1:0]   be,
   output logic [DATA_W-1:0] rx_data,
   output logic [BE_W-1:0]   rx_be,
   output logic              rx_valid,
   input  logic              rx_ready,
   input  logic [DATA_W-1:0] tx_data,
   input  logic [BE_W-1:0]   tx_be,
   input  logic              tx_valid,
   output logic              tx_ready,
   input  logic              periph_ready,
   output logic              busy
`ifdef FT60X_STATS_EN
   ,
   output logic [31:0]       rx_word_count,
   output logic [31:0]       tx_word_count
`endif
);

   typedef enum logic [2:0] {IDLE, RX_OE, RX_RD, TX, TURN} state_t;
   typedef enum logic {DIR_RX, DIR_TX} dir_t;

   state_t           state;
   dir_t             prio_r;
   logic [CNT_W-1:0] burst_cnt;
   logic [CNT_W-1:0] burst_next;
   logic             rx_req;
   logic             tx_req;
   logic             rx_xfer;
   logic             tx_xfer;
   logic             bus_drive;
   logic             burst_full;

   assign rx_req = !usb_rx_empty && rx_ready;
   assign tx_req = tx_valid && !usb_tx_full;

   // Strobes follow the inputs combinationally so a dropped rx_ready or periph_ready stops the bus this cycle.
   assign rx_xfer     = periph_ready && (state == RX_RD) && rx_ready && !usb_rx_empty;
   assign tx_xfer     = periph_ready && (state == TX) && tx_req;
   assign usb_outen_l = !(periph_ready && ((state == RX_OE) || (state == RX_RD)));
   assign usb_rden_l  = !(periph_ready && (state == RX_RD) && rx_ready);
   assign usb_wren_l  = !tx_xfer;
   assign tx_ready    = tx_xfer;
   assign usb_rst_l   = rst_l;
   assign busy        = (state != IDLE);

   assign bus_drive = periph_ready && (state == TX);
   assign data      = bus_drive ? tx_data : {DATA_W{1'bz}};
   assign be        = bus_drive ? tx_be : {BE_W{1'bz}};

   always_comb begin
      burst_next = burst_cnt;
      if ((rx_xfer || tx_xfer) && (burst_cnt != CNT_W'(MAX_BURST)))
         burst_next = burst_cnt + CNT_W'(1);
   end

   assign burst_full = (burst_next == CNT_W'(MAX_BURST));

   // Main FSM: burst counter only lives inside RX_RD/TX, so it is cleared on every entry.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state     <= IDLE;
         prio_r    <= DIR_RX;
         burst_cnt <= '0;
         rx_valid  <= 1'b0;
         rx_data   <= '0;
         rx_be     <= '0;
      end else begin
         rx_valid <= rx_xfer;
         if (rx_xfer) begin
            rx_data <= data;
            rx_be   <= be;
         end
         burst_cnt <= ((state == RX_RD) || (state == TX)) ? burst_next : '0;
         if (!periph_ready) begin
            if (state == RX_RD)
               prio_r <= DIR_TX;
            else if (state == TX)
               prio_r <= DIR_RX;
            state <= IDLE;
         end else begin
            case (state)
               IDLE: begin
                  if (rx_req && (!tx_req || (prio_r == DIR_RX)))
                     state <= RX_OE;
                  else if (tx_req)
                     state <= TX;
               end
               RX_OE: state <= RX_RD;
               RX_RD: begin
                  if (usb_rx_empty || !rx_ready || (burst_full && tx_req)) begin
                     state  <= TURN;
                     prio_r <= DIR_TX;
                  end
               end
               TX: begin
                  if (!tx_req || (burst_full && rx_req)) begin
                     state  <= TURN;
                     prio_r <= DIR_RX;
                  end
               end
               TURN:    state <= IDLE;
               default: state <= IDLE;
            endcase
         end
      end
   end

`ifdef FT60X_STATS_EN
   // Lifetime word counters, saturating and cleared only by reset.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         rx_word_count <= '0;
         tx_word_count <= '0;
      end else begin
         if (rx_xfer && (rx_word_count != 32'hFFFF_FFFF))
            rx_word_count <= rx_word_count + 32'd1;
         if (tx_xfer && (tx_word_count != 32'hFFFF_FFFF))
            tx_word_count <= tx_word_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_ft60x_bus_controller.sv
// Self-checking bench for ft60x_bus_controller: directed scenarios plus randomized traffic
// checked by a host-side FIFO model, word scoreboards and bus protocol rules.
module tb_ft60x_bus_controller;

   localparam int DATA_W    = 32;
   localparam int BE_W      = DATA_W / 8;
   localparam int MAX_BURST = 4;

   typedef logic [BE_W+DATA_W-1:0] word_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst_l;
   logic              usb_tx_full;
   logic              usb_rx_empty;
   logic              usb_wren_l;
   logic              usb_rden_l;
   logic              usb_outen_l;
   logic              usb_rst_l;
   wire  [DATA_W-1:0] data;
   wire  [BE_W-1:0]   be;
   logic [DATA_W-1:0] rx_data;
   logic [BE_W-1:0]   rx_be;
   logic              rx_valid;
   logic              rx_ready;
   logic [DATA_W-1:0] tx_data;
   logic [BE_W-1:0]   tx_be;
   logic              tx_valid;
   logic              tx_ready;
   logic              periph_ready;
   logic              busy;
`ifdef FT60X_STATS_EN
   logic [31:0]       rx_word_count;
   logic [31:0]       tx_word_count;
`endif

   logic [DATA_W-1:0] host_data;
   logic [BE_W-1:0]   host_be;

   // The FT60x drives the bus whenever OE_N is low.
   assign data = !usb_outen_l ? host_data : {DATA_W{1'bz}};
   assign be   = !usb_outen_l ? host_be : {BE_W{1'bz}};

   ft60x_bus_controller #(.DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
      .clk          (clk),
      .rst_l        (rst_l),
      .usb_tx_full  (usb_tx_full),
      .usb_rx_empty (usb_rx_empty),
      .usb_wren_l   (usb_wren_l),
      .usb_rden_l   (usb_rden_l),
      .usb_outen_l  (usb_outen_l),
      .usb_rst_l    (usb_rst_l),
      .data         (data),
      .be           (be),
      .rx_data      (rx_data),
      .rx_be        (rx_be),
      .rx_valid     (rx_valid),
      .rx_ready     (rx_ready),
      .tx_data      (tx_data),
      .tx_be        (tx_be),
      .tx_valid     (tx_valid),
      .tx_ready     (tx_ready),
      .periph_ready (periph_ready),
      .busy         (busy)
`ifdef FT60X_STATS_EN
      ,
      .rx_word_count(rx_word_count),
      .tx_word_count(tx_word_count)
`endif
   );

   int    n_checks = 0;
   int    n_fail   = 0;
   word_t host_q[$];
   word_t tx_q[$];
   word_t exp_rx[$];
   logic  tx_en    = 1'b0;
   logic  host_stall = 1'b0;

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // One bus cycle: inputs change 1ns after the rising edge, outputs are examined at the falling edge.
   task automatic applyStimulus(input logic rdy, input logic full, input logic pr,
                                input logic en, input logic stall);
      @(posedge clk);
      #1;
      rx_ready     = rdy;
      usb_tx_full  = full;
      periph_ready = pr;
      tx_en        = en;
      host_stall   = stall;
      usb_rx_empty = host_stall || (host_q.size() == 0);
      {host_be, host_data} = (host_q.size() != 0) ? host_q[0] : '0;
      tx_valid     = tx_en && (tx_q.size() != 0);
      {tx_be, tx_data} = (tx_q.size() != 0) ? tx_q[0] : '0;
      @(negedge clk);
   endtask

   logic cap;
   logic cap_prev    = 1'b0;
   logic expect_turn = 1'b0;
   logic prev_outen  = 1'b1;
   logic prev_wren   = 1'b1;
   int   rx_run      = 0;
   int   tx_run      = 0;
   word_t popped;

   // Host model and protocol rules, evaluated every cycle between edges.
   always @(negedge clk) begin
      if (!rst_l) begin
         cap_prev    = 1'b0;
         expect_turn = 1'b0;
         prev_outen  = 1'b1;
         prev_wren   = 1'b1;
         rx_run      = 0;
         tx_run      = 0;
         exp_rx.delete();
      end else begin
         checkOutput("rx_valid_latency", rx_valid, cap_prev);
         if (cap_prev && (exp_rx.size() != 0)) begin
            popped = exp_rx.pop_front();
            checkOutput("rx_word", {rx_be, rx_data}, popped);
         end
         checkOutput("tx_ready_eq_wren", tx_ready, !usb_wren_l);
         cap = !usb_rden_l && !usb_rx_empty;
         if (cap && (host_q.size() != 0))
            exp_rx.push_back(host_q.pop_front());
         if (!usb_wren_l) begin
            checkOutput("wren_legal", tx_valid && !usb_tx_full && periph_ready, 1'b1);
            checkOutput("turnaround_to_tx", prev_outen, 1'b1);
            if (tx_q.size() != 0) begin
               popped = tx_q.pop_front();
               checkOutput("tx_bus_word", {be, data}, popped);
            end
         end
         if (!usb_outen_l)
            checkOutput("turnaround_to_rx", prev_wren, 1'b1);
         if (!periph_ready)
            checkOutput("periph_quiet", {usb_wren_l, usb_rden_l, usb_outen_l, tx_ready}, 4'b1110);
         if (expect_turn)
            checkOutput("burst_limit_yield", {usb_outen_l, usb_wren_l}, 2'b11);
         expect_turn = 1'b0;
         if (usb_outen_l) rx_run = 0;
         if (!busy) tx_run = 0;
         if (cap) begin
            rx_run++;
            if ((rx_run >= MAX_BURST) && tx_valid && !usb_tx_full) expect_turn = 1'b1;
         end
         if (!usb_wren_l) begin
            tx_run++;
            if ((tx_run >= MAX_BURST) && !usb_rx_empty && rx_ready) expect_turn = 1'b1;
         end
         cap_prev   = cap;
         prev_outen = usb_outen_l;
         prev_wren  = usb_wren_l;
      end
   end

   localparam logic [3:0] RX_EXP [8] = '{4'b1100, 4'b0110, 4'b0010, 4'b0011,
                                         4'b0011, 4'b0011, 4'b1110, 4'b1100};
   localparam logic [2:0] TX_EXP [6] = '{3'b100, 3'b011, 3'b011, 3'b101, 3'b101, 3'b100};
   localparam logic [2:0] BURST_EXP [16] = '{3'b111, 3'b011, 3'b001, 3'b001, 3'b001, 3'b001,
                                             3'b111, 3'b111, 3'b110, 3'b110, 3'b110, 3'b110,
                                             3'b111, 3'b111, 3'b011, 3'b001};
   logic [DATA_W-1:0] rx_words [3];
   word_t w;
   logic  found;

   initial begin
      rx_words     = '{32'hA1, 32'hA2, 32'hA3};
      rst_l        = 1'b0;
      usb_tx_full  = 1'b0;
      usb_rx_empty = 1'b1;
      rx_ready     = 1'b1;
      tx_valid     = 1'b0;
      tx_data      = '0;
      tx_be        = '0;
      periph_ready = 1'b1;
      host_data    = '0;
      host_be      = '0;

      repeat (3) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("rst_strobes", {usb_wren_l, usb_rden_l, usb_outen_l}, 3'b111);
      checkOutput("rst_rx_valid", rx_valid, 1'b0);
      checkOutput("rst_rx_data", {rx_be, rx_data}, '0);
      checkOutput("rst_tx_ready", tx_ready, 1'b0);
      checkOutput("rst_busy", busy, 1'b0);
      checkOutput("rst_usb_rst", usb_rst_l, 1'b0);
      @(posedge clk);
      #1 rst_l = 1'b1;
      checkOutput("usb_rst_follows", usb_rst_l, 1'b1);

      for (int c = 0; c < 20; c++) begin
         applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
         checkOutput("idle_quiet", {usb_wren_l, usb_rden_l, usb_outen_l, busy}, 4'b1110);
      end

      $display("[TB] RX burst of three words");
      for (int i = 0; i < 3; i++) host_q.push_back({4'hF, rx_words[i]});
      for (int c = 0; c < 8; c++) begin
         applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
         checkOutput("rx3_seq", {usb_outen_l, usb_rden_l, busy, rx_valid}, RX_EXP[c]);
         if ((c >= 3) && (c <= 5)) checkOutput("rx3_data", {rx_be, rx_data}, {4'hF, rx_words[c-3]});
      end

      $display("[TB] TX until FIFO full");
      for (int i = 0; i < 3; i++) tx_q.push_back({4'hF, 32'hB0 + 32'(i)});
      for (int c = 0; c < 6; c++) begin
         applyStimulus(1'b1, c >= 3, 1'b1, 1'b1, 1'b0);
         checkOutput("tx_full_seq", {usb_wren_l, tx_ready, busy}, TX_EXP[c]);
      end
      tx_q.delete();
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

      $display("[TB] Both directions pending with burst limit");
      for (int i = 0; i < 12; i++) begin
         host_q.push_back({4'hF, 32'hC00 + 32'(i)});
         tx_q.push_back({4'h3, 32'hD00 + 32'(i)});
      end
      for (int c = 0; c < 16; c++) begin
         applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
         checkOutput("burst_pattern", {usb_outen_l, usb_rden_l, usb_wren_l}, BURST_EXP[c]);
      end
      repeat (4) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      host_q.delete();
      tx_q.delete();

      $display("[TB] rx_ready drop mid burst");
      for (int i = 0; i < 4; i++) host_q.push_back({4'h5, 32'hE00 + 32'(i)});
      for (int c = 0; c < 14; c++) begin
         applyStimulus(!((c >= 4) && (c <= 6)), 1'b0, 1'b1, 1'b0, 1'b0);
         if ((c == 2) || (c == 3)) checkOutput("rdy_drop_rden_low", usb_rden_l, 1'b0);
         if (c == 4) checkOutput("rdy_drop_rden_high", usb_rden_l, 1'b1);
         if (c == 5) checkOutput("rdy_drop_turn", busy, 1'b1);
         if (c == 6) checkOutput("rdy_drop_idle", busy, 1'b0);
      end
      checkOutput("no_word_lost", host_q.size(), 0);
      checkOutput("rx_all_delivered", exp_rx.size(), 0);

      $display("[TB] periph_ready drop during TX");
      for (int i = 0; i < 8; i++) tx_q.push_back({4'hC, 32'hF00 + 32'(i)});
      for (int c = 0; c < 5; c++) begin
         applyStimulus(1'b1, 1'b0, !((c == 3) || (c == 4)), c < 4, 1'b0);
         if ((c == 1) || (c == 2)) checkOutput("pr_tx_active", usb_wren_l, 1'b0);
         if (c == 3) checkOutput("pr_drop_now", {usb_wren_l, tx_ready}, 2'b10);
         if (c == 4) checkOutput("pr_drop_idle", busy, 1'b0);
      end
      tx_q.delete();
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

      $display("[TB] Randomized traffic");
      for (int i = 0; i < 3000; i++) begin
         if (($urandom_range(0, 2) == 0) && (host_q.size() < 16)) begin
            w = word_t'({$urandom(), $urandom()});
            host_q.push_back(w);
         end
         if (($urandom_range(0, 2) == 0) && (tx_q.size() < 16)) begin
            w = word_t'({$urandom(), $urandom()});
            tx_q.push_back(w);
         end
         applyStimulus($urandom_range(0, 9) != 0, $urandom_range(0, 4) == 0,
                       $urandom_range(0, 49) != 0, $urandom_range(0, 7) != 0,
                       $urandom_range(0, 5) == 0);
      end
      repeat (100) applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      checkOutput("rand_host_drained", host_q.size(), 0);
      checkOutput("rand_tx_drained", tx_q.size(), 0);
      checkOutput("rand_rx_delivered", exp_rx.size(), 0);

      $display("[TB] Asynchronous reset mid TX burst");
      for (int i = 0; i < 8; i++) tx_q.push_back({4'hA, 32'h5A00 + 32'(i)});
      found = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (!found) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
            found = !usb_wren_l;
         end
      end
      checkOutput("wait_tx_start", found, 1'b1);
      @(posedge clk);
      #2 rst_l = 1'b0;
      #1;
      checkOutput("async_rst_strobes", {usb_wren_l, usb_rden_l, usb_outen_l, tx_ready}, 4'b1110);
      checkOutput("async_rst_state", {busy, rx_valid}, 2'b00);
      checkOutput("async_rst_rx_data", {rx_be, rx_data}, '0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
      $finish;
   end

endmodule
